// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner ids and counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Combinational grant pick: data wins unless fetch is waiting and the data streak is saturated.
module mem_grant_select
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
   input  logic streak_sat,
   output logic grant_valid,
   output logic grant_owner
);

   always_comb begin
      grant_valid = if_req | d_req;
      grant_owner = OWN_IF;
      if (d_req && !(if_req && streak_sat)) begin
         grant_owner = OWN_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and data requesters,
// one access at a time (IDLE -> ISSUE -> WAIT x LATENCY -> RESP), stalling the core meanwhile.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int ADDR_W       = 32,
   parameter  int DATA_W       = 32,
   parameter  int LATENCY      = 1,
   parameter  int MAX_D_STREAK = 4,
   localparam int STREAK_W     = $clog2(MAX_D_STREAK + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                core_ena,
   output logic [1:0]          fsm_state,
   output logic [STREAK_W-1:0] d_streak
);

   // Handshake: a requester raises req with stable fields and holds them until its
   // one-cycle valid pulse; req is ignored during that pulse, so a new request may
   // be presented in the following cycle and is arbitrated in IDLE.

   arb_state_t          state, state_next;
   logic [CNT_W-1:0]    cnt;
   logic [STREAK_W-1:0] streak;
   logic                own;
   logic [ADDR_W-1:0]   lat_addr;
   logic                lat_we;
   logic [DATA_W-1:0]   lat_wdata;
   logic                grant_valid;
   logic                grant_owner;
   logic                streak_sat;

   assign streak_sat = (streak == STREAK_W'(MAX_D_STREAK));

   mem_grant_select u_grant (
      .if_req      (if_req),
      .d_req       (d_req),
      .streak_sat  (streak_sat),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      if_valid   = 1'b0;
      d_valid    = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_valid) state_next = ISSUE;
         end
         ISSUE: begin
            mem_req    = 1'b1;
            mem_we     = lat_we;
            state_next = WAIT;
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) state_next = RESP;
         end
         RESP: begin
            if_valid   = (own == OWN_IF);
            d_valid    = (own == OWN_D);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt       <= '0;
         streak    <= '0;
         own       <= OWN_IF;
         lat_addr  <= '0;
         lat_we    <= 1'b0;
         lat_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_valid) begin
                  own <= grant_owner;
                  if (grant_owner == OWN_D) begin
                     lat_addr  <= d_addr;
                     lat_we    <= d_we;
                     lat_wdata <= d_wdata;
                     // Streak only grows while fetch is actually being held off.
                     if (!if_req) begin
                        streak <= '0;
                     end else if (!streak_sat) begin
                        streak <= streak + 1'b1;
                     end
                  end else begin
                     lat_addr  <= if_addr;
                     lat_we    <= 1'b0;
                     lat_wdata <= '0;
                     streak    <= '0;
                  end
               end
            end
            ISSUE: begin
               cnt <= CNT_W'(LATENCY);
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  if (own == OWN_D) begin
                     d_rdata <= mem_rdata;
                  end else begin
                     if_rdata <= mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign core_ena  = ~((if_req & ~if_valid) | (d_req & ~d_valid));
   assign fsm_state = state;
   assign d_streak  = streak;

endmodule
